// File: rtl/card_shoe_pkg.sv
// Shared types and helpers for the card shoe: FSM states, deck size, LFSR taps, card scoring.
package card_pkg;

    typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, READY, ADVANCE} shoe_state_t;

    localparam int          DECK_SIZE = 52;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // rank = idx[5:2]: 0 is the ace, 9..12 are 10/J/Q/K
    function automatic logic [3:0] card_value(input logic [5:0] idx);
        logic [3:0] rank;
        rank = idx[5:2];
        if (rank == 4'd0)
            return 4'd11;
        else if (rank >= 4'd9)
            return 4'd10;
        else
            return rank + 4'd1;
    endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Handshake between the card shoe (slave, card producer) and the game FSM (master).
interface card_shoe_if;
    logic       shuf;
    logic       card_used;
    logic       rdy;
    logic [5:0] card;
    logic [3:0] val;
    logic [5:0] left;
    logic       busy;
    logic       empty;

    modport master (output shuf, card_used, input rdy, card, val, left, busy, empty);
    modport slave  (input shuf, card_used, output rdy, card, val, left, busy, empty);
endinterface

// File: rtl/card_shoe_lfsr.sv
// 16-bit Galois LFSR feeding the shuffler; reset reloads SEED, which must be nonzero.
import card_pkg::*;

module shoe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else if (step)
            q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    end

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: Fisher-Yates shuffle with LFSR rejection sampling, one card per RDY/card_used.
// Build option CARD_SHOE_ENTROPY_EN: LFSR free-runs every clock so SHUF timing perturbs the deck.
import card_pkg::*;

module card_shoe #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter bit          AUTO_RESHUF = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    card_shoe_if.slave   bus
);

    shoe_state_t state;
    logic [5:0]  deck [DECK_SIZE];
    logic [5:0]  i;
    logic [5:0]  ptr;
    logic [5:0]  j;
    logic [5:0]  card_next;
    logic [15:0] lfsr_q;
    logic        step;
    logic        lfsr_unused;

`ifdef CARD_SHOE_ENTROPY_EN
    assign step = 1'b1;
`else
    assign step = (state == SHUFFLE);
`endif

    shoe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .q    (lfsr_q)
    );

    assign j           = lfsr_q[5:0];
    assign lfsr_unused = ^lfsr_q[15:6];

    // The final swap (i==1) lands in the same edge that enters READY, so
    // the first card is taken from the post-swap view of deck[0].
    always_comb begin
        card_next = deck[ptr];
        if (state == SHUFFLE)
            card_next = (j == 6'd0) ? deck[1] : deck[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.rdy   <= 1'b0;
            bus.card  <= 6'd0;
            bus.val   <= 4'd0;
            bus.left  <= 6'd0;
            bus.busy  <= 1'b0;
            bus.empty <= 1'b1;
            i         <= 6'd0;
            ptr       <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.shuf) begin
                        state    <= INIT;
                        bus.busy <= 1'b1;
                    end
                end
                INIT: begin
                    for (int k = 0; k < DECK_SIZE; k++)
                        deck[k] <= 6'(k);
                    i     <= 6'(DECK_SIZE - 1);
                    state <= SHUFFLE;
                end
                SHUFFLE: begin
                    if (j <= i) begin
                        deck[i] <= deck[j];
                        deck[j] <= deck[i];
                        if (i == 6'd1) begin
                            ptr       <= 6'd0;
                            bus.left  <= 6'(DECK_SIZE);
                            bus.rdy   <= 1'b1;
                            bus.busy  <= 1'b0;
                            bus.empty <= 1'b0;
                            bus.card  <= card_next;
                            bus.val   <= card_value(card_next);
                            state     <= READY;
                        end else begin
                            i <= i - 6'd1;
                        end
                    end
                end
                READY: begin
                    if (bus.shuf) begin
                        bus.rdy   <= 1'b0;
                        bus.busy  <= 1'b1;
                        bus.empty <= 1'b1;
                        state     <= INIT;
                    end else if (bus.card_used) begin
                        ptr      <= ptr + 6'd1;
                        bus.left <= bus.left - 6'd1;
                        bus.rdy  <= 1'b0;
                        if (bus.left == 6'd1)
                            bus.empty <= 1'b1;
                        state    <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (bus.shuf) begin
                        bus.busy  <= 1'b1;
                        bus.empty <= 1'b1;
                        state     <= INIT;
                    end else if (bus.left != 6'd0) begin
                        bus.rdy  <= 1'b1;
                        bus.card <= card_next;
                        bus.val  <= card_value(card_next);
                        state    <= READY;
                    end else begin
                        bus.busy <= AUTO_RESHUF;
                        state    <= AUTO_RESHUF ? INIT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: reset, full deal, held card_used, SHUF collisions, mid-shuffle reset, manual mode.
module tb_card_shoe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    card_shoe_if sa ();
    card_shoe_if sm ();

    card_shoe #(.SEED(16'hACE1), .AUTO_RESHUF(1'b1)) dut_auto (.clk(clk), .rst(rst), .bus(sa.slave));
    card_shoe #(.SEED(16'hACE1), .AUTO_RESHUF(1'b0)) dut_man  (.clk(clk), .rst(rst), .bus(sm.slave));

    int         tests = 0;
    int         fails = 0;
    logic [5:0] seq1 [52];

    function automatic logic [3:0] exp_val(input logic [5:0] c);
        int r;
        r = int'(c) / 4;
        if (r == 0)  return 4'd11;
        if (r >= 9)  return 4'd10;
        return 4'(r + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy_auto();
        int n = 0;
        while (n < 2000 && !sa.rdy) begin
            tick();
            n++;
        end
        tests++;
        if (sa.rdy !== 1'b1) begin
            fails++;
            $display("FAIL auto_wait_rdy: rdy=%b after %0d cycles, required 1 within 2000", sa.rdy, n);
        end
    endtask

    task automatic wait_rdy_man();
        int n = 0;
        while (n < 2000 && !sm.rdy) begin
            tick();
            n++;
        end
        tests++;
        if (sm.rdy !== 1'b1) begin
            fails++;
            $display("FAIL man_wait_rdy: rdy=%b after %0d cycles, required 1 within 2000", sm.rdy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({sa.rdy, sa.left, sa.empty, sa.busy} !== {1'b0, 6'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%b left=%0d empty=%b busy=%b, required 0/0/1/0",
                     sa.rdy, sa.left, sa.empty, sa.busy);
        end
        tests++;
        if ({sm.rdy, sm.left, sm.empty, sm.busy} !== {1'b0, 6'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state_man: rdy=%b left=%0d empty=%b busy=%b, required 0/0/1/0",
                     sm.rdy, sm.left, sm.empty, sm.busy);
        end
        sa.card_used = 1'b1;
        repeat (3) tick();
        sa.card_used = 1'b0;
        tick();
        tests++;
        if ({sa.rdy, sa.left, sa.empty, sa.busy} !== {1'b0, 6'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_used_ignored: rdy=%b left=%0d empty=%b busy=%b, required 0/0/1/0",
                     sa.rdy, sa.left, sa.empty, sa.busy);
        end
    endtask

    task automatic test_full_deal();
        logic [51:0] seen = '0;
        int dups = 0;
        int sum  = 0;
        sa.shuf = 1'b1;
        tick();
        sa.shuf = 1'b0;
        tests++;
        if (sa.busy !== 1'b1) begin
            fails++;
            $display("FAIL deal_busy_init: busy=%b, required 1", sa.busy);
        end
        wait_rdy_auto();
        for (int n = 0; n < 52; n++) begin
            tests++;
            if (sa.rdy !== 1'b1 || sa.left !== 6'(52 - n)) begin
                fails++;
                $display("FAIL deal_present[%0d]: rdy=%b left=%0d, required 1/%0d", n, sa.rdy, sa.left, 52 - n);
            end
            tests++;
            if (sa.val !== exp_val(sa.card)) begin
                fails++;
                $display("FAIL deal_val[%0d]: card=%0d val=%0d, required %0d", n, sa.card, sa.val, exp_val(sa.card));
            end
            seq1[n] = sa.card;
            if (sa.card > 6'd51 || seen[sa.card]) dups++;
            else seen[sa.card] = 1'b1;
            sum += int'(sa.val);
            sa.card_used = 1'b1;
            tick();
            sa.card_used = 1'b0;
            tests++;
            if (sa.rdy !== 1'b0 || sa.left !== 6'(51 - n)) begin
                fails++;
                $display("FAIL deal_advance[%0d]: rdy=%b left=%0d, required 0/%0d", n, sa.rdy, sa.left, 51 - n);
            end
            if (n == 51) begin
                tests++;
                if (sa.empty !== 1'b1) begin
                    fails++;
                    $display("FAIL deal_empty_last: empty=%b, required 1", sa.empty);
                end
            end
            tick();
        end
        tests++;
        if (sa.busy !== 1'b1) begin
            fails++;
            $display("FAIL auto_reshuffle_busy: busy=%b, required 1", sa.busy);
        end
        tests++;
        if (dups != 0 || seen !== {52{1'b1}}) begin
            fails++;
            $display("FAIL deal_unique: dups=%0d seen=%h, required 0/%h", dups, seen, {52{1'b1}});
        end
        tests++;
        if (sum != 380) begin
            fails++;
            $display("FAIL deal_val_sum: sum=%0d, required 380", sum);
        end
    endtask

    task automatic test_hold_used();
        wait_rdy_auto();
        tests++;
        if (sa.left !== 6'd52) begin
            fails++;
            $display("FAIL hold_left_start: left=%0d, required 52", sa.left);
        end
        sa.card_used = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (sa.rdy !== ((k % 2) == 0)) begin
                fails++;
                $display("FAIL hold_rdy_pattern[%0d]: rdy=%b, required %b", k, sa.rdy, (k % 2) == 0);
            end
            tick();
        end
        sa.card_used = 1'b0;
        tests++;
        if (sa.left !== 6'd49 || sa.rdy !== 1'b1) begin
            fails++;
            $display("FAIL hold_consumed: left=%0d rdy=%b, required 49/1", sa.left, sa.rdy);
        end
    endtask

    task automatic test_shuf_collide();
        sa.shuf = 1'b1;
        sa.card_used = 1'b1;
        tick();
        sa.shuf = 1'b0;
        sa.card_used = 1'b0;
        tests++;
        if (sa.busy !== 1'b1 || sa.rdy !== 1'b0 || sa.left !== 6'd49) begin
            fails++;
            $display("FAIL collide_shuf_wins: busy=%b rdy=%b left=%0d, required 1/0/49", sa.busy, sa.rdy, sa.left);
        end
        wait_rdy_auto();
        tests++;
        if (sa.left !== 6'd52) begin
            fails++;
            $display("FAIL collide_new_deck: left=%0d, required 52", sa.left);
        end
    endtask

    task automatic test_reset_mid_shuffle();
        sa.shuf = 1'b1;
        tick();
        sa.shuf = 1'b0;
        repeat (11) tick();
        tests++;
        if (sa.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: busy=%b, required 1", sa.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({sa.busy, sa.rdy, sa.empty, sa.left} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
            fails++;
            $display("FAIL mid_reset_idle: busy=%b rdy=%b empty=%b left=%0d, required 0/0/1/0",
                     sa.busy, sa.rdy, sa.empty, sa.left);
        end
        sa.shuf = 1'b1;
        tick();
        sa.shuf = 1'b0;
        wait_rdy_auto();
        tests++;
        if (sa.card !== seq1[0]) begin
            fails++;
            $display("FAIL mid_first_card: card=%0d, required %0d", sa.card, seq1[0]);
        end
    endtask

    task automatic test_manual();
        sm.shuf = 1'b1;
        tick();
        sm.shuf = 1'b0;
        wait_rdy_man();
        for (int n = 0; n < 52; n++) begin
            tests++;
            if (sm.rdy !== 1'b1 || sm.card !== seq1[n]) begin
                fails++;
                $display("FAIL man_repeat_card[%0d]: rdy=%b card=%0d, required 1/%0d", n, sm.rdy, sm.card, seq1[n]);
            end
            sm.card_used = 1'b1;
            tick();
            sm.card_used = 1'b0;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({sm.rdy, sm.busy, sm.empty, sm.left} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
                fails++;
                $display("FAIL man_stays_idle[%0d]: rdy=%b busy=%b empty=%b left=%0d, required 0/0/1/0",
                         k, sm.rdy, sm.busy, sm.empty, sm.left);
            end
            sm.card_used = (k == 1);
            tick();
        end
        sm.card_used = 1'b0;
    endtask

    initial begin
        sa.shuf = 1'b0;
        sa.card_used = 1'b0;
        sm.shuf = 1'b0;
        sm.card_used = 1'b0;
        test_reset();
        test_full_deal();
        test_hold_used();
        test_shuf_collide();
        test_reset_mid_shuffle();
        test_manual();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
